// File: rtl/tab_hash_pkg.sv
// Shared types and sizing for the tabulation-hash sequencer and its table bank.
// Widths live here so the sequencer, bus interface and bank always agree.
package tab_hash_pkg;

  localparam int KEY_BITS   = 32;
  localparam int CHUNK_BITS = 8;
  localparam int DBITS      = 32;

  function automatic int nchunk_of(int key_bits, int chunk_bits);
    return key_bits / chunk_bits;
  endfunction

  localparam int NCHUNK   = nchunk_of(KEY_BITS, CHUNK_BITS);
  localparam int SEL_BITS = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NLOC     = 1 << CHUNK_BITS;

  typedef logic [KEY_BITS-1:0]   key_t;
  typedef logic [CHUNK_BITS-1:0] chunk_t;
  typedef logic [SEL_BITS-1:0]   sel_t;
  typedef logic [DBITS-1:0]      data_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_e;

  // Chunk 0 is the least-significant CHUNK_BITS of the key.
  function automatic chunk_t key_chunk(key_t k, sel_t i);
    return k[int'(i)*CHUNK_BITS +: CHUNK_BITS];
  endfunction

endpackage

// File: rtl/tab_hash_sequencer_if.sv
// Key-in / hash-out handshakes plus the table-bank read port of the sequencer.
interface tab_hash_sequencer_if;
  import tab_hash_pkg::*;

  logic   in_valid;
  logic   in_ready;
  key_t   in_key;
  sel_t   tbl_sel;
  chunk_t tbl_addr;
  data_t  tbl_data;
  logic   out_valid;
  logic   out_ready;
  data_t  out_hash;
  logic   busy;

  // Environment side: key producer, hash consumer and table bank.
  modport master (
    output in_valid, in_key, out_ready, tbl_data,
    input  in_ready, tbl_sel, tbl_addr, out_valid, out_hash, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_key, out_ready, tbl_data,
    output in_ready, tbl_sel, tbl_addr, out_valid, out_hash, busy
  );

endinterface

// File: rtl/tab_hash_table_bank.sv
// NCHUNK static, asynchronously read lookup tables muxed by tbl_sel.
// MODE 0: entry a of table t = a << (CHUNK_BITS*t); MODE 1: entry a = a in every table.
module tab_hash_table_bank
  import tab_hash_pkg::*;
#(
  parameter int MODE = 0
) (
  input  sel_t   tbl_sel,
  input  chunk_t tbl_addr,
  output data_t  tbl_data
);

  data_t rom [NCHUNK][NLOC];

  // Each table's contents are fixed at elaboration and become constant ROM.
  for (genvar t = 0; t < NCHUNK; t++) begin : g_tbl
    for (genvar a = 0; a < NLOC; a++) begin : g_loc
      localparam data_t WORD = (MODE == 0) ? (DBITS'(a) << (CHUNK_BITS*t)) : DBITS'(a);
      assign rom[t][a] = WORD;
    end
  end

  assign tbl_data = rom[tbl_sel][tbl_addr];

endmodule

// File: rtl/tab_hash_sequencer.sv
// Serial tabulation-hash controller: one table lookup per cycle, XOR-accumulated,
// result held on a valid/ready output until consumed.
module tab_hash_sequencer
  import tab_hash_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  tab_hash_sequencer_if.slave  bus
);

  state_e state;
  sel_t   idx;
  key_t   key_q;
  data_t  acc;
  data_t  out_hash_q;

  logic accept;
  assign accept = bus.in_valid && bus.in_ready;

  // A finished hash consumed this cycle frees the slot for a new key in the same edge.
  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == LOOKUP);
  assign bus.out_hash  = out_hash_q;
  assign bus.tbl_sel   = (state == LOOKUP) ? idx : '0;
  assign bus.tbl_addr  = (state == LOOKUP) ? key_chunk(key_q, idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      key_q      <= '0;
      acc        <= '0;
      out_hash_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key_q <= bus.in_key;
            acc   <= '0;
            idx   <= '0;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          acc <= acc ^ bus.tbl_data;
          idx <= idx + 1'b1;
          if (idx == sel_t'(NCHUNK-1)) begin
            out_hash_q <= acc ^ bus.tbl_data;
            idx        <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (accept) begin
            key_q <= bus.in_key;
            acc   <= '0;
            idx   <= '0;
            state <= LOOKUP;
          end else if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
